flash_audio_sequencer: RTL and testbench
========================================

Name: flash_audio_sequencer

Overview:
Sequences word reads from flash through the existing start/ready read FSM and turns the 32-bit words into a stream of 16-bit audio samples. Each word holds two samples, one in each half.
- Keeps the flash word-address counter, with forward/backward playback, wrap-around, pause and restart.
- Presents one sample per sample tick.
- Sits between the flash read FSM and the audio output path, controlled by keyboard-derived play/dir/restart signals.

Parameters:
ADDR_W, 23, flash word-address width.
MAX_ADDR, 23'h7FFFF, last word address of the audio region; region is 0..MAX_ADDR.

Ports:
inclk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
flag_start  output  1  one-cycle start pulse to the read FSM.
flag_ready  input  1  read FSM finish indication; one cycle high per completed read.
flash_readdata  input  32  flash word; valid in the cycle flag_ready=1.
flash_address  output  ADDR_W  current word address to the flash controller.
sample_tick  input  1  single-cycle sample-rate strobe, already synchronous to inclk.
play  input  1  1 = consume ticks; 0 = pause (hold output).
dir_fwd  input  1  1 = forward playback, 0 = backward.
restart  input  1  single-cycle pulse: jump to start of region for the current direction.
audio_sample  output  16  current sample.
sample_valid  output  1  one-cycle pulse when audio_sample updates.

Behaviour:
Reset (async, reset=0):
- state=IDLE, flash_address=0, flag_start=0, audio_sample=0, sample_valid=0.
- Word latch, pending-tick bit and restart-pending bit are all cleared.

States: IDLE, FETCH_START, FETCH_WAIT, OUT_FIRST, OUT_SECOND, ADVANCE.
- IDLE -> FETCH_START unconditionally, on the first clock after reset release.
- FETCH_START: flag_start=1 for exactly this cycle; latch word_dir<=dir_fwd; -> FETCH_WAIT. flag_start is never held high for more than one cycle.
- FETCH_WAIT: wait for flag_ready. On flag_ready=1, latch flash_readdata and go -> OUT_FIRST.
- OUT_FIRST: on a consumed tick, output the first half and go -> OUT_SECOND.
- OUT_SECOND: on a consumed tick, output the second half and go -> ADVANCE.
- Half order:
  - word_dir=1: first half = [15:0], second half = [31:16].
  - word_dir=0: first half = [31:16], second half = [15:0].
- Output timing: audio_sample is registered the cycle after the tick is consumed, and sample_valid pulses in that same cycle.
- ADVANCE -> FETCH_START (1 cycle). Address update:
  - If restart-pending: address = 0 when dir_fwd=1, MAX_ADDR when dir_fwd=0; clear restart-pending.
  - Else if dir_fwd=1: address+1, wrapping MAX_ADDR -> 0.
  - Else: address-1, wrapping 0 -> MAX_ADDR.
  - dir_fwd is sampled here, not latched earlier.

Tick consumption:
- A tick is consumed only when play=1 and state is OUT_FIRST or OUT_SECOND.
- A tick arriving with play=1 in any other state sets a 1-deep pending bit. The pending bit is consumed as a tick on the first cycle in OUT_FIRST/OUT_SECOND.
- A tick arriving while pending is already set is dropped (underrun).
- play=0: ticks are ignored and not recorded. Fetch still proceeds, so the FSM parks in OUT_FIRST/OUT_SECOND. audio_sample holds its value and sample_valid stays 0.

Restart:
- restart in OUT_FIRST/OUT_SECOND: abandon the current word, go -> ADVANCE with restart-pending set. No sample is output from the abandoned word.
- restart in FETCH_START/FETCH_WAIT: set restart-pending. The flash transaction is never aborted; the FSM completes FETCH_WAIT, then goes -> ADVANCE directly, discarding the word.
- restart simultaneous with a tick in OUT_*: restart wins and the tick becomes pending.

Direction:
- A direction change mid-word does not alter the half order of the word already fetched.
- It takes effect at the next ADVANCE.

Other rules:
- flash_address only changes in ADVANCE and is stable throughout a fetch.
- Reset mid-fetch returns to IDLE immediately. The read FSM shares the same reset.

Optional Feature:
Macro UNDERRUN_COUNT_EN.
- Defined: adds output underrun_count[15:0], reset 0. It increments by 1, saturating at 16'hFFFF, on each dropped tick.
- Undefined: the port and counter are absent and dropped ticks are silently lost.

Decomposition:
Package flash_audio_pkg holds:
- the state enum;
- ADDR_W, SAMPLE_W=16, WORD_W=32;
- the half-select helper function.

One natural sub-module, flash_addr_counter: up/down counter with wrap at 0/MAX_ADDR and synchronous load for restart.

Test Plan:
- Reset release, play=1, dir_fwd=1, word@0=32'hBBBB_AAAA, tick every 20 cycles -> one flag_start pulse; after flag_ready, samples 16'hAAAA then 16'hBBBB; flash_address steps to 1.
- dir_fwd=0 from reset -> address 0 decrements and wraps to 23'h7FFFF. Word 32'hBBBB_AAAA outputs 16'hBBBB first, then 16'hAAAA.
- Forward at address 23'h7FFFF, after the second sample -> flash_address=0 and the next fetch is issued.
- play=0 for 100 ticks while in OUT_FIRST -> sample_valid never pulses and audio_sample holds. After play=1, the next tick outputs the first half.
- Hold flag_ready off for 50 cycles and pulse sample_tick 3 times -> one tick pending, then consumed on entering OUT_FIRST. With UNDERRUN_COUNT_EN, underrun_count=2.
- restart pulsed during FETCH_WAIT at address 5 (forward) -> the fetch completes, the word is discarded, and the next flag_start uses flash_address=0 with no sample output in between.

Source files
------------

// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio sequencer: FSM states,
// data widths and the helper that picks which half of a word to play.
package flash_audio_pkg;

    localparam int ADDR_W   = 23;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_START,
        FETCH_WAIT,
        OUT_FIRST,
        OUT_SECOND,
        ADVANCE
    } state_t;

    // Forward words play low half first; backward words play high half first.
    function automatic logic [SAMPLE_W-1:0] half_select(
        input logic [WORD_W-1:0] word,
        input logic              word_dir,
        input logic              second
    );
        return (word_dir ^ second) ? word[SAMPLE_W-1:0] : word[WORD_W-1:SAMPLE_W];
    endfunction

endpackage

// File: rtl/flash_addr_counter.sv
// Flash word-address counter: up/down stepping with wrap over 0..MAX_ADDR,
// plus a load that jumps to the start of the region for the given direction.
module flash_addr_counter #(
    parameter int              ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic              fwd,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= fwd ? '0 : MAX_ADDR;
        end else if (step) begin
            if (fwd) begin
                addr <= (addr == MAX_ADDR) ? '0 : addr + 1'b1;
            end else begin
                addr <= (addr == '0) ? MAX_ADDR : addr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_audio_sequencer.sv
// Fetches 32-bit flash words via the start/ready read FSM and plays them as two
// 16-bit samples per word, one per sample tick. Optional macro UNDERRUN_COUNT_EN.
module flash_audio_sequencer #(
    parameter int                ADDR_W   = flash_audio_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
    input  logic              inclk,
    input  logic              reset,
    output logic              flag_start,
    input  logic              flag_ready,
    input  logic [31:0]       flash_readdata,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              sample_tick,
    input  logic              play,
    input  logic              dir_fwd,
    input  logic              restart,
    output logic [15:0]       audio_sample,
    output logic              sample_valid
`ifdef UNDERRUN_COUNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    import flash_audio_pkg::*;

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   word_reg;
    logic                word_dir_reg;
    logic                pending_reg, pending_next;
    logic                restart_pend_reg, restart_pend_next;
    logic                in_out, tick_now, consume, drop, restart_req;
    logic                adv_step, adv_load;

    always_comb begin
        state_next        = state_reg;
        pending_next      = pending_reg;
        restart_pend_next = restart_pend_reg;
        drop              = 1'b0;
        in_out      = (state_reg == OUT_FIRST) || (state_reg == OUT_SECOND);
        tick_now    = play & sample_tick;
        restart_req = restart_pend_reg | restart;
        // A restart in an output state wins over a tick; the tick is kept pending.
        consume     = in_out & play & (tick_now | pending_reg) & ~restart;

        if (consume) begin
            pending_next = pending_reg & tick_now;
        end else begin
            drop         = tick_now & pending_reg;
            pending_next = pending_reg | tick_now;
        end

        if (state_reg == ADVANCE) begin
            restart_pend_next = 1'b0;
        end else if (restart) begin
            restart_pend_next = 1'b1;
        end

        case (state_reg)
            IDLE:        state_next = FETCH_START;
            FETCH_START: state_next = FETCH_WAIT;
            FETCH_WAIT:  if (flag_ready) state_next = restart_req ? ADVANCE : OUT_FIRST;
            OUT_FIRST: begin
                if (restart)      state_next = ADVANCE;
                else if (consume) state_next = OUT_SECOND;
            end
            OUT_SECOND:  if (restart || consume) state_next = ADVANCE;
            ADVANCE:     state_next = FETCH_START;
            default:     state_next = IDLE;
        endcase

        adv_load = (state_reg == ADVANCE) & restart_req;
        adv_step = (state_reg == ADVANCE) & ~restart_req;
    end

    assign flag_start = (state_reg == FETCH_START);

    always_ff @(posedge inclk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            word_reg         <= '0;
            word_dir_reg     <= 1'b0;
            pending_reg      <= 1'b0;
            restart_pend_reg <= 1'b0;
            audio_sample     <= '0;
            sample_valid     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pending_reg      <= pending_next;
            restart_pend_reg <= restart_pend_next;
            sample_valid     <= consume;
            if (consume) begin
                audio_sample <= half_select(word_reg, word_dir_reg, state_reg == OUT_SECOND);
            end
            if (state_reg == FETCH_START) begin
                word_dir_reg <= dir_fwd;
            end
            if ((state_reg == FETCH_WAIT) && flag_ready && !restart_req) begin
                word_reg <= flash_readdata;
            end
        end
    end

`ifdef UNDERRUN_COUNT_EN
    always_ff @(posedge inclk or negedge reset) begin
        if (!reset) begin
            underrun_count <= '0;
        end else if (drop && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

    flash_addr_counter #(
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR)
    ) u_addr (
        .clk   (inclk),
        .rst_n (reset),
        .step  (adv_step),
        .load  (adv_load),
        .fwd   (dir_fwd),
        .addr  (flash_address)
    );

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Scoreboard bench for flash_audio_sequencer: a flash model checks fetch
// addresses, a monitor checks samples against hand-computed expectations.
module tb_flash_audio_sequencer;

    logic        inclk;
    logic        reset;
    logic        flag_start;
    logic        flag_ready;
    logic [31:0] flash_readdata;
    logic [22:0] flash_address;
    logic        sample_tick;
    logic        play;
    logic        dir_fwd;
    logic        restart;
    logic [15:0] audio_sample;
    logic        sample_valid;
`ifdef UNDERRUN_COUNT_EN
    logic [15:0] underrun_count;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ready_delay = 3;
    logic [15:0] exp_samp_q[$];
    logic [22:0] exp_addr_q[$];

    flash_audio_sequencer dut (
        .inclk          (inclk),
        .reset          (reset),
        .flag_start     (flag_start),
        .flag_ready     (flag_ready),
        .flash_readdata (flash_readdata),
        .flash_address  (flash_address),
        .sample_tick    (sample_tick),
        .play           (play),
        .dir_fwd        (dir_fwd),
        .restart        (restart),
        .audio_sample   (audio_sample),
        .sample_valid   (sample_valid)
`ifdef UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    initial begin
        inclk = 1'b0;
        forever #5 inclk = ~inclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [22:0] a);
        case (a)
            23'd0:       return 32'hBBBB_AAAA;
            23'd1:       return 32'h4444_3333;
            23'h7FFFF:   return 32'h2222_1111;
            default:     return {4'hD, a[11:0], 4'hC, a[11:0]};
        endcase
    endfunction

    // Flash read model: answers each start pulse after ready_delay cycles.
    initial begin
        logic [22:0] a;
        flag_ready     = 1'b0;
        flash_readdata = '0;
        forever begin
            @(negedge inclk);
            if (reset && flag_start) begin
                a = flash_address;
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got addr %h expected none", a);
                end else begin
                    check("fetch_addr", {9'd0, a}, {9'd0, exp_addr_q.pop_front()});
                end
                $display("txn fetch addr=%h", a);
                @(negedge inclk);
                check("start_one_cycle", {31'd0, flag_start}, 32'd0);
                repeat (ready_delay - 1) @(negedge inclk);
                flag_ready     = 1'b1;
                flash_readdata = word_at(a);
                @(negedge inclk);
                flag_ready     = 1'b0;
            end
        end
    end

    // Sample monitor
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge inclk);
            if (reset && sample_valid) begin
                if (exp_samp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %h expected none", audio_sample);
                end else begin
                    e = exp_samp_q.pop_front();
                    check("sample", {16'd0, audio_sample}, {16'd0, e});
                    $display("txn sample got=%h exp=%h", audio_sample, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge inclk);
    endtask

    task automatic tick();
        @(negedge inclk);
        sample_tick = 1'b1;
        @(negedge inclk);
        sample_tick = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge inclk);
        restart = 1'b1;
        @(negedge inclk);
        restart = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge inclk);
        reset       = 1'b0;
        sample_tick = 1'b0;
        restart     = 1'b0;
        cycles(3);
        check("rst_flag_start", {31'd0, flag_start}, 32'd0);
        check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_audio_sample", {16'd0, audio_sample}, 32'd0);
        check("rst_flash_address", {9'd0, flash_address}, 32'd0);
`ifdef UNDERRUN_COUNT_EN
        check("rst_underrun", {16'd0, underrun_count}, 32'd0);
`endif
        reset = 1'b1;
    endtask

    task automatic wait_start();
        for (int k = 0; k < 20 && !flag_start; k++) @(negedge inclk);
        check("start_seen", {31'd0, flag_start}, 32'd1);
    endtask

    task automatic end_phase(input string name);
        cycles(20);
        check({name, "_samples_left"}, exp_samp_q.size(), 32'd0);
        check({name, "_fetches_left"}, exp_addr_q.size(), 32'd0);
        exp_samp_q.delete();
        exp_addr_q.delete();
    endtask

    initial begin
        reset       = 1'b0;
        sample_tick = 1'b0;
        restart     = 1'b0;
        play        = 1'b1;
        dir_fwd     = 1'b1;

        // Forward playback of word 0, then advance to 1
        exp_addr_q = '{23'd0, 23'd1};
        exp_samp_q = '{16'hAAAA, 16'hBBBB};
        do_reset();
        repeat (2) begin cycles(19); tick(); end
        cycles(15);
        check("fwd_addr", {9'd0, flash_address}, 32'd1);
        end_phase("fwd");

        // Backward playback: 0 wraps to MAX_ADDR, halves reversed
        dir_fwd    = 1'b0;
        exp_addr_q = '{23'd0, 23'h7FFFF, 23'h7FFFE};
        exp_samp_q = '{16'hBBBB, 16'hAAAA, 16'h2222, 16'h1111};
        do_reset();
        repeat (4) begin cycles(19); tick(); end
        cycles(15);
        check("bwd_addr", {9'd0, flash_address}, 32'h7FFFE);
        end_phase("bwd");

        // Restart backward to MAX_ADDR, flip to forward mid-word, wrap to 0
        dir_fwd    = 1'b0;
        exp_addr_q = '{23'd0, 23'h7FFFF, 23'd0};
        exp_samp_q = '{16'h2222, 16'h1111};
        do_reset();
        cycles(15);
        pulse_restart();
        cycles(4);
        dir_fwd = 1'b1;
        cycles(15);
        repeat (2) begin cycles(19); tick(); end
        cycles(15);
        check("wrap_addr", {9'd0, flash_address}, 32'd0);
        end_phase("wrap");

        // Paused: 100 ticks ignored, then first half on resume
        play       = 1'b0;
        exp_addr_q = '{23'd0};
        exp_samp_q = '{16'hAAAA};
        do_reset();
        cycles(15);
        repeat (100) tick();
        check("pause_hold", {16'd0, audio_sample}, 32'd0);
        play = 1'b1;
        cycles(2);
        tick();
        cycles(10);
        check("resume_sample", {16'd0, audio_sample}, 32'h0000AAAA);
        end_phase("pause");

        // Slow fetch: three ticks while waiting, one pending, two dropped
        ready_delay = 50;
        exp_addr_q  = '{23'd0};
        exp_samp_q  = '{16'hAAAA};
        do_reset();
        wait_start();
        cycles(3);
        repeat (3) begin tick(); cycles(2); end
`ifdef UNDERRUN_COUNT_EN
        check("underrun_count", {16'd0, underrun_count}, 32'd2);
`endif
        cycles(60);
        end_phase("pending");

        // Restart during FETCH_WAIT at address 5 discards the word
        ready_delay = 20;
        exp_addr_q  = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd4, 23'd5, 23'd0};
        exp_samp_q  = '{16'hAAAA, 16'hBBBB, 16'h3333, 16'h4444, 16'hC002,
                        16'hD002, 16'hC003, 16'hD003, 16'hC004, 16'hD004};
        do_reset();
        repeat (10) begin cycles(29); tick(); end
        wait_start();
        check("restart_from_addr", {9'd0, flash_address}, 32'd5);
        cycles(3);
        pulse_restart();
        cycles(40);
        check("restart_addr", {9'd0, flash_address}, 32'd0);
        end_phase("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
